alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Command-side initiator for the clocked 32-bit ALU (op codes 000 add, 001 and, 010 or, 011 sub, 100 mul low-32, 101 unsigned set-less-than).
- Accepts register-to-register commands over a valid/ready handshake.
- Reads operands from an internal 8x32 register file, drives the ALU's A/B/op inputs, and captures the ALU's registered Res/Zflag one cycle later.
- Writes the result back and reports completion.
- Sits between the instruction front end and the ALU instance.

Parameters:
NREGS, 8, register file depth (power of two; register index width = log2(NREGS))
W, 32, datapath width; must match the ALU

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_op  in  3  000-101 ALU ops; 110 LOADI; 111 illegal
cmd_rd  in  3  destination register
cmd_rs1  in  3  source A register
cmd_rs2  in  3  source B register
cmd_imm  in  W  immediate for LOADI
alu_A  out  W  registered operand A to ALU
alu_B  out  W  registered operand B to ALU
alu_op  out  3  registered op to ALU
alu_Res  in  W  ALU result (registered inside ALU)
alu_Zflag  in  1  ALU zero flag
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_rd  out  3  destination of completed command
rsp_data  out  W  value written (0 for illegal)
rsp_err  out  1  completed command was illegal (op 111)
status_z  out  1  Zflag of the most recent completed ALU op
dbg_addr  in  3  debug read index
dbg_data  out  W  combinational read of regfile[dbg_addr] (r0 reads 0)

Behaviour:
- Reset (RST=1 at an edge), including mid-operation:
  - state to IDLE; all registers cleared to 0.
  - alu_A, alu_B, alu_op, rsp_* and status_z go to 0; cmd_ready=1 in the following cycle.
  - An in-flight command is dropped with no write and no response.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, cmd_ready=1. On cmd_valid at an edge, latch rd/op:
  - ALU op (000-101): alu_A<=reg[rs1], alu_B<=reg[rs2] (r0 reads 0), alu_op<=cmd_op; go to ISSUE.
  - LOADI (110): write cmd_imm to reg[rd]; go to RESP with rsp_data=cmd_imm. status_z is unchanged.
  - Illegal (111): no write; go to RESP with rsp_err=1, rsp_data=0.
- ISSUE: alu_* are held stable. The ALU samples them at the end of this cycle. Go to CAPTURE.
- CAPTURE: alu_Res and alu_Zflag are valid. At the edge, write alu_Res to reg[rd], update status_z from alu_Zflag, load rsp_data/rsp_rd, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; go to IDLE.
- Latency and throughput:
  - ALU op: accept edge to rsp_valid = 3 cycles.
  - LOADI/illegal: 1 cycle.
  - Throughput: at most one command in flight, cmd_ready=0 outside IDLE.
- Register 0:
  - Hardwired zero; writes with rd=0 are discarded.
  - rsp_data still reports the computed value; status_z is still updated.
- Hazards:
  - None by construction. The write completes before the next accept, so back-to-back dependent commands read the new value.
- Widths:
  - All arithmetic is done by the ALU (mul = low W bits, sub wraps mod 2^W, compare unsigned).
  - The block performs no arithmetic.
- dbg_data reflects a write in the cycle after the write edge.
- alu_* outputs are held at their last values outside ISSUE (no toggling).

Decomposition:
- Shared package alu_pkg holds:
  - op constants OP_ADD=000, OP_AND=001, OP_OR=010, OP_SUB=011, OP_MUL=100, OP_SLT=101, OP_LOADI=110, OP_ILL=111.
  - W and NREGS defaults.
  - FSM state encoding.
- One sub-module, alu_regfile: NREGS x W, one synchronous write port, two combinational read ports plus a debug read port, r0 forced to zero, synchronous clear on RST.
- The bench instantiates alu_issue_ctrl together with the real ALU.

Test Plan:
- RST mid-CAPTURE of an ADD -> no rsp_valid; dbg r1..r7 = 0; status_z=0; cmd_ready=1 on the next cycle.
- LOADI r1=7, LOADI r2=5, ADD r3=r1+r2 -> rsp_valid exactly 3 cycles after the ADD accept; rsp_data=12; dbg r3=12; status_z=0.
- SUB r4=r2-r1 -> rsp_data=0xFFFFFFFE, status_z=0. Then SUB r5=r1-r1 -> rsp_data=0, status_z=1.
- MUL r6 with r6 loaded to 0x10000 and multiplied by itself -> rsp_data=0 (low 32 bits), status_z=1. Then SLT r7=r2<r1 -> 1.
- cmd op=111 -> rsp_valid after 1 cycle, rsp_err=1, regs unchanged. ADD with rd=0 -> rsp_data=12, but dbg r0 stays 0.
- cmd_valid held high continuously -> cmd_ready low during ISSUE/CAPTURE/RESP; each command accepted exactly once; alu_A/alu_B stable during ISSUE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issue path: op codes, default sizes
// and the issue controller state encoding.
package alu_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_NREGS = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_LOADI = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // True for op codes that must travel through the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/alu.sv
// Clocked W-bit ALU: result and zero flag are registered, so they become
// valid one cycle after the operands are presented.
module alu
    import alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   op,
    output logic [W-1:0] Res,
    output logic         Zflag
);

    logic [W-1:0] res_d;
    logic [W-1:0] res_q;
    logic         zflag_q;

    // Combinational operation select; unused op codes yield zero.
    always_comb begin
        res_d = '0;
        case (op)
            OP_ADD:  res_d = A + B;
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_SUB:  res_d = A - B;
            OP_MUL:  res_d = A * B;
            OP_SLT:  res_d = {{(W-1){1'b0}}, (A < B)};
            default: res_d = '0;
        endcase
    end

    // Output registers for result and zero flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zflag_q <= (res_d == '0);
        end
    end

    assign Res   = res_q;
    assign Zflag = zflag_q;

endmodule

// File: rtl/alu_regfile.sv
// NREGS x W register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port. Register 0 is
// hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int W     = DEF_W,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr_a,
    output logic [W-1:0]  rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [W-1:0]  rd_data_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    logic [W-1:0] mem_q [NREGS];
    logic [W-1:0] mem_d [NREGS];

    // Next register contents: apply the write unless it targets r0.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr] = wr_data;
        end
        mem_d[0] = '0;
    end

    // Register storage with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side initiator for the clocked ALU. Accepts one register-to-register
// command at a time, reads operands from the local register file, drives the
// ALU, writes the captured result back and pulses a completion response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int W     = DEF_W,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [W-1:0]  cmd_imm,
    output logic [W-1:0]  alu_A,
    output logic [W-1:0]  alu_B,
    output logic [2:0]    alu_op,
    input  logic [W-1:0]  alu_Res,
    input  logic          alu_Zflag,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_rd,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_err,
    output logic          status_z,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    state_e        state_q,    state_d;
    logic [W-1:0]  alu_a_q,    alu_a_d;
    logic [W-1:0]  alu_b_q,    alu_b_d;
    logic [2:0]    alu_op_q,   alu_op_d;
    logic [AW-1:0] rd_q,       rd_d;
    logic [AW-1:0] rsp_rd_q,   rsp_rd_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q,  rsp_err_d;
    logic          status_z_q, status_z_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  rd_data_a;
    logic [W-1:0]  rd_data_b;

    alu_regfile #(
        .NREGS (NREGS),
        .W     (W),
        .AW    (AW)
    ) u_regfile (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (cmd_rs1),
        .rd_data_a (rd_data_a),
        .rd_addr_b (cmd_rs2),
        .rd_data_b (rd_data_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Next-state, register-file write and response loading for the issue FSM.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        status_z_d = status_z_q;
        wr_en      = 1'b0;
        wr_addr    = rd_q;
        wr_data    = alu_Res;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rd_d = cmd_rd;
                    if (is_alu_op(cmd_op)) begin
                        alu_a_d  = rd_data_a;
                        alu_b_d  = rd_data_b;
                        alu_op_d = cmd_op;
                        state_d  = ST_ISSUE;
                    end else if (cmd_op == OP_LOADI) begin
                        wr_en      = 1'b1;
                        wr_addr    = cmd_rd;
                        wr_data    = cmd_imm;
                        rsp_rd_d   = cmd_rd;
                        rsp_data_d = cmd_imm;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        rsp_rd_d   = cmd_rd;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                wr_en      = 1'b1;
                wr_addr    = rd_q;
                wr_data    = alu_Res;
                status_z_d = alu_Zflag;
                rsp_rd_d   = rd_q;
                rsp_data_d = alu_Res;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            status_z_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            status_z_q <= status_z_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign status_z  = status_z_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl driving a real ALU: directed vector
// table, randomized commands against a register-array reference model,
// back-to-back valid streaming and reset in the middle of an operation.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic [31:0] alu_Res;
    logic        alu_Zflag;
    logic        rsp_valid;
    logic [2:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        status_z;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural registers and zero status.
    logic [31:0] m_regs [8];
    logic        m_z;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    alu_issue_ctrl #(.NREGS(8), .W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_op    (alu_op),
        .alu_Res   (alu_Res),
        .alu_Zflag (alu_Zflag),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .status_z  (status_z),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    alu #(.W(32)) u_alu (
        .CLK   (CLK),
        .RST   (RST),
        .A     (alu_A),
        .B     (alu_B),
        .op    (alu_op),
        .Res   (alu_Res),
        .Zflag (alu_Zflag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hang guard: the run must always reach a verdict.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Architectural meaning of each ALU op code.
    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        case (op)
            OP_ADD: return a + b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_SUB: return a - b;
            OP_MUL: begin
                prod = longint'(a) * longint'(b);
                return prod[31:0];
            end
            OP_SLT: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one command and report what the block must answer.
    task automatic model_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [31:0] imm,
                             output logic [31:0] data, output logic err, output int lat);
        if (op == OP_LOADI) begin
            data = imm; err = 1'b0; lat = 1;
            if (rd != 0) m_regs[rd] = imm;
        end else if (op == OP_ILL) begin
            data = 32'd0; err = 1'b1; lat = 1;
        end else begin
            data = alu_ref(op, m_regs[rs1], m_regs[rs2]);
            err = 1'b0; lat = 3;
            m_z = (data == 32'd0);
            if (rd != 0) m_regs[rd] = data;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_z = 1'b0;
    endtask

    // Issue one command and wait (bounded) for its response pulse.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic [31:0] imm,
                                 output logic [31:0] data, output logic err,
                                 output logic [2:0] rdo, output int lat);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_wait actual=0 required=1");
        end
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (!rsp_valid) lat = -1;
        data = rsp_data;
        err  = rsp_err;
        rdo  = rsp_rd;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checkOutput($sformatf("%s_dbg_r%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    initial begin
        logic [31:0] data, exp_data, hold_a, hold_b, exp_a, exp_b;
        logic        err, exp_err;
        logic [2:0]  rdo, op, rd, rs1, rs2, exp_rd;
        logic [31:0] imm;
        int          lat, exp_lat, busy, resets_seen;

        vecs[0]  = '{OP_LOADI, 3'd1, 3'd0, 3'd0, 32'd7,       32'd7,        1'b0, 1'b0, 1};
        vecs[1]  = '{OP_LOADI, 3'd2, 3'd0, 3'd0, 32'd5,       32'd5,        1'b0, 1'b0, 1};
        vecs[2]  = '{OP_ADD,   3'd3, 3'd1, 3'd2, 32'd0,       32'd12,       1'b0, 1'b0, 3};
        vecs[3]  = '{OP_SUB,   3'd4, 3'd2, 3'd1, 32'd0,       32'hFFFFFFFE, 1'b0, 1'b0, 3};
        vecs[4]  = '{OP_SUB,   3'd5, 3'd1, 3'd1, 32'd0,       32'd0,        1'b0, 1'b1, 3};
        vecs[5]  = '{OP_LOADI, 3'd6, 3'd0, 3'd0, 32'h10000,   32'h10000,    1'b0, 1'b1, 1};
        vecs[6]  = '{OP_MUL,   3'd6, 3'd6, 3'd6, 32'd0,       32'd0,        1'b0, 1'b1, 3};
        vecs[7]  = '{OP_SLT,   3'd7, 3'd2, 3'd1, 32'd0,       32'd1,        1'b0, 1'b0, 3};
        vecs[8]  = '{OP_ILL,   3'd3, 3'd1, 3'd2, 32'hDEAD,    32'd0,        1'b1, 1'b0, 1};
        vecs[9]  = '{OP_ADD,   3'd0, 3'd1, 3'd2, 32'd0,       32'd12,       1'b0, 1'b0, 3};
        vecs[10] = '{OP_AND,   3'd1, 3'd1, 3'd2, 32'd0,       32'd5,        1'b0, 1'b0, 3};
        vecs[11] = '{OP_OR,    3'd2, 3'd3, 3'd7, 32'd0,       32'd13,       1'b0, 1'b0, 3};

        RST = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_imm = '0; dbg_addr = '0;
        model_reset();
        tick(); tick();
        RST = 1'b0;

        // Reset state.
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_alu_A", alu_A, 32'd0);
        checkOutput("rst_status_z", {31'd0, status_z}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        check_all_regs("rst");

        // Directed vector table.
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].imm,
                          data, err, rdo, lat);
            model_cmd(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].imm,
                      exp_data, exp_err, exp_lat);
            checkOutput($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            checkOutput($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
            checkOutput($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
            checkOutput($sformatf("vec%0d_rd", v), {29'd0, rdo}, {29'd0, vecs[v].rd});
            checkOutput($sformatf("vec%0d_z", v), {31'd0, status_z}, {31'd0, vecs[v].exp_z});
            if (vecs[v].rd == 3'd0) begin
                dbg_addr = 3'd0;
                #1;
                checkOutput($sformatf("vec%0d_r0", v), dbg_data, 32'd0);
            end
            tick();
            checkOutput($sformatf("vec%0d_one_pulse", v), {31'd0, rsp_valid}, 32'd0);
        end
        check_all_regs("table");

        // Randomized commands against the reference model.
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = OP_LOADI;
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            applyStimulus(op, rd, rs1, rs2, imm, data, err, rdo, lat);
            model_cmd(op, rd, rs1, rs2, imm, exp_data, exp_err, exp_lat);
            checkOutput($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
            checkOutput($sformatf("rnd%0d_data", n), data, exp_data);
            checkOutput($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, exp_err});
            checkOutput($sformatf("rnd%0d_rd", n), {29'd0, rdo}, {29'd0, rd});
            checkOutput($sformatf("rnd%0d_z", n), {31'd0, status_z}, {31'd0, m_z});
            dbg_addr = rd;
            #1;
            checkOutput($sformatf("rnd%0d_dbg", n), dbg_data, m_regs[rd]);
        end
        check_all_regs("random");

        // cmd_valid held high: one accept per four cycles, operands held.
        while (!cmd_ready) tick();
        busy = 0; exp_a = '0; exp_b = '0; hold_a = '0; hold_b = '0;
        exp_data = '0; exp_rd = '0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 48; c++) begin
            checkOutput($sformatf("stream%0d_ready", c), {31'd0, cmd_ready}, {31'd0, (busy == 0)});
            checkOutput($sformatf("stream%0d_rsp_valid", c), {31'd0, rsp_valid}, {31'd0, (busy == 1)});
            if (busy == 3) begin
                checkOutput($sformatf("stream%0d_alu_A", c), alu_A, exp_a);
                checkOutput($sformatf("stream%0d_alu_B", c), alu_B, exp_b);
                hold_a = alu_A; hold_b = alu_B;
            end else if (busy == 2 || busy == 1) begin
                checkOutput($sformatf("stream%0d_A_hold", c), alu_A, hold_a);
                checkOutput($sformatf("stream%0d_B_hold", c), alu_B, hold_b);
            end
            if (busy == 1) begin
                checkOutput($sformatf("stream%0d_data", c), rsp_data, exp_data);
                checkOutput($sformatf("stream%0d_rd", c), {29'd0, rsp_rd}, {29'd0, exp_rd});
                checkOutput($sformatf("stream%0d_z", c), {31'd0, status_z}, {31'd0, m_z});
            end
            cmd_op  = 3'($urandom_range(0, 5));
            cmd_rd  = 3'($urandom_range(1, 7));
            cmd_rs1 = 3'($urandom_range(0, 7));
            cmd_rs2 = 3'($urandom_range(0, 7));
            cmd_imm = $urandom;
            if (busy == 0) begin
                exp_a  = m_regs[cmd_rs1];
                exp_b  = m_regs[cmd_rs2];
                exp_rd = cmd_rd;
                model_cmd(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, exp_data, exp_err, exp_lat);
                busy = 3;
            end else begin
                busy--;
            end
            tick();
        end
        cmd_valid = 1'b0;
        while (busy > 0) begin
            tick();
            busy--;
        end
        check_all_regs("stream");

        // Reset while an ADD sits in CAPTURE.
        applyStimulus(OP_LOADI, 3'd1, 3'd0, 3'd0, 32'd9, data, err, rdo, lat);
        model_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 32'd9, exp_data, exp_err, exp_lat);
        applyStimulus(OP_SUB, 3'd5, 3'd1, 3'd1, 32'd0, data, err, rdo, lat);
        model_cmd(OP_SUB, 3'd5, 3'd1, 3'd1, 32'd0, exp_data, exp_err, exp_lat);
        checkOutput("pre_rst_z", {31'd0, status_z}, 32'd1);
        tick();
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        checkOutput("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("midrst_z", {31'd0, status_z}, 32'd0);
        checkOutput("midrst_alu_A", alu_A, 32'd0);
        checkOutput("midrst_alu_op", {29'd0, alu_op}, 32'd0);
        resets_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) resets_seen++;
            tick();
        end
        checkOutput("midrst_no_rsp", 32'(resets_seen), 32'd0);
        check_all_regs("midrst");

        // Block is usable again after the aborted command.
        applyStimulus(OP_LOADI, 3'd2, 3'd0, 3'd0, 32'h55, data, err, rdo, lat);
        checkOutput("post_rst_data", data, 32'h55);
        checkOutput("post_rst_lat", 32'(lat), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
